// File: rtl/doodle_pkg.sv
// Shared definitions for the doodle game control stage and its renderer.
// Contents: the game-phase enum, platform geometry constants and the fixed
// platform table (left edge, top edge, scroll flag). Each platform's right
// edge is xlo + PLAT_W.
package doodle_pkg;

  typedef enum logic [1:0] {
    StInit = 2'd0,
    StUp   = 2'd1,
    StDown = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam int unsigned NUM_PLATFORMS = 12;
  localparam int unsigned PLAT_W        = 64;
  localparam int unsigned PLAT_H        = 16;

  localparam logic [10:0] PLAT_XLO [NUM_PLATFORMS] = '{
    11'd256, 11'd374, 11'd600, 11'd200, 11'd256, 11'd374,
    11'd600, 11'd200, 11'd300, 11'd400, 11'd600, 11'd600
  };

  localparam logic [10:0] PLAT_TOP [NUM_PLATFORMS] = '{
    11'd200, 11'd490, 11'd330, 11'd100, 11'd470, 11'd145,
    11'd145, 11'd330, 11'd300, 11'd360, 11'd72,  11'd490
  };

  // 1: platform moves with v_counter, 0: fixed on screen.
  localparam logic PLAT_SCROLL [NUM_PLATFORMS] = '{
    1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1
  };

endpackage

// File: rtl/platform_hit_detect.sv
// Combinational landing detector: reports whether the doodle's feet touch the
// top of any platform.
// Ports:
//   xpos, ypos  - doodle centre position (hCount / vCount)
//   v_counter   - current platform scroll offset
//   hit         - feet lie within HIT_WINDOW rows of a platform top, inside
//                 its horizontal span widened by the doodle radius
module platform_hit_detect
  import doodle_pkg::*;
#(
  parameter int unsigned DOODLE_RADIUS = 10,
  parameter int unsigned HIT_WINDOW    = 4
) (
  input  logic [9:0] xpos,
  input  logic [9:0] ypos,
  input  logic [9:0] v_counter,
  output logic       hit
);

  logic [10:0] foot_y;
  logic [10:0] x_reach;
  logic [10:0] top;

  // 11-bit sums keep every comparison free of overflow.
  always_comb begin
    foot_y  = {1'b0, ypos} + 11'(DOODLE_RADIUS);
    // xpos >= xlo - R rewritten as xpos + R >= xlo to avoid subtraction.
    x_reach = {1'b0, xpos} + 11'(DOODLE_RADIUS);
    top     = '0;
    hit     = 1'b0;
    for (int i = 0; i < NUM_PLATFORMS; i++) begin
      top = PLAT_TOP[i] + (PLAT_SCROLL[i] ? {1'b0, v_counter} : 11'd0);
      if ((foot_y >= top) && (foot_y <= top + 11'(HIT_WINDOW - 1)) &&
          (x_reach >= PLAT_XLO[i]) &&
          ({1'b0, xpos} <= PLAT_XLO[i] + 11'(PLAT_W + DOODLE_RADIUS))) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/doodle_game_fsm.sv
// Game-control FSM sitting upstream of the VGA drawing stage.
// Ports:
//   clk, rst                  - game clock, synchronous active-high reset
//   start                     - debounced start button level (edge detected here)
//   xpos, ypos, up_count      - doodle position and climb count from the drawer
//   q_I, q_Up, q_Down, q_Done - one-hot phase strobes
//   v_counter                 - platform scroll offset
//   score                     - saturating landing count
module doodle_game_fsm
  import doodle_pkg::*;
#(
  parameter int unsigned JUMP_HEIGHT   = 100,
  parameter int unsigned DOODLE_RADIUS = 10,
  parameter int unsigned FLOOR_Y       = 515,
  parameter int unsigned SCROLL_LINE   = 200,
  parameter int unsigned SCROLL_STEP   = 2,
  parameter int unsigned HIT_WINDOW    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] xpos,
  input  logic [9:0] ypos,
  input  logic [7:0] up_count,
  output logic       q_I,
  output logic       q_Up,
  output logic       q_Down,
  output logic       q_Done,
  output logic [9:0] v_counter,
  output logic [7:0] score
);

  state_e      state;
  logic        start_q;
  logic        start_rise;
  logic        hit_raw;
  logic        hit_q;
  logic [10:0] foot_y;

  platform_hit_detect #(
    .DOODLE_RADIUS(DOODLE_RADIUS),
    .HIT_WINDOW   (HIT_WINDOW)
  ) u_hit (
    .xpos     (xpos),
    .ypos     (ypos),
    .v_counter(v_counter),
    .hit      (hit_raw)
  );

  assign start_rise = start & ~start_q;
  assign foot_y     = {1'b0, ypos} + 11'(DOODLE_RADIUS);

  assign q_I    = (state == StInit);
  assign q_Up   = (state == StUp);
  assign q_Down = (state == StDown);
  assign q_Done = (state == StDone);

  always_ff @(posedge clk) begin
    // start_q tracks the button even in reset, so a button held through reset
    // is not seen as a fresh press afterwards.
    start_q <= start;
    if (rst) begin
      state     <= StInit;
      v_counter <= '0;
      score     <= '0;
      hit_q     <= 1'b0;
    end else begin
      // Cleared outside DOWN so a stale hit cannot fire on re-entry.
      hit_q <= (state == StDown) && hit_raw;
      unique case (state)
        StInit: begin
          v_counter <= '0;
          score     <= '0;
          if (start_rise) state <= StUp;
        end
        StUp: begin
          if (up_count >= 8'(JUMP_HEIGHT)) state <= StDown;
          if (ypos < 10'(SCROLL_LINE)) v_counter <= v_counter + 10'(SCROLL_STEP);
        end
        StDown: begin
          // A landing wins over the floor check in the same cycle.
          if (hit_q) begin
            state <= StUp;
            if (score != 8'hFF) score <= score + 8'd1;
          end else if (foot_y > 11'(FLOOR_Y)) begin
            state <= StDone;
          end
        end
        StDone: begin
          if (start_rise) begin
            state     <= StInit;
            v_counter <= '0;
            score     <= '0;
          end
        end
        default: state <= StInit;
      endcase
    end
  end

endmodule
